// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI slave types, the {CPOL,CPHA} clock mode and the IDLE/SHIFT state
package spi_pkg;
  typedef struct packed {
    logic cpol;
    logic cpha;
  } clk_mode_t;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/spi_sync.sv
// spi_sync: 2-flop synchronizer plus edge detect (in: clk, reset, d; out: rise, fall of synchronized d)
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [2:0] sh_q, sh_d;
  always_comb sh_d = {sh_q[1:0], d};
  always_ff @(posedge clk) sh_q <= reset ? {3{RST_VAL}} : sh_d;
  assign rise = sh_q[1] & ~sh_q[2];
  assign fall = ~sh_q[1] & sh_q[2];
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI slave, modes 0-3 (in: clk, reset, clk_mode, SCLK, SS_n, MOSI, tx_data; out: MISO, MISO_oe, tx_ready, rx_data, rx_valid, abort)
module spi_slave
  import spi_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  clk_mode_t        clk_mode,
  input  logic             SCLK,
  input  logic             SS_n,
  input  logic             MOSI,
  output logic             MISO,
  output logic             MISO_oe,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             abort
);
  localparam int CW = $clog2(WIDTH);
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic lead, trail, smp, shf, wrap;
  logic [1:0] mosi_q, mosi_d;
  state_t state_q, state_d;
  clk_mode_t mode_q, mode_d;
  logic [WIDTH-1:0] tx_q, tx_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d, abort_q, abort_d;
  spi_sync #(.RST_VAL(1'b0)) u_sclk (
    .clk  (clk),
    .reset(reset),
    .d    (SCLK),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );
  spi_sync #(.RST_VAL(1'b1)) u_ss (
    .clk  (clk),
    .reset(reset),
    .d    (SS_n),
    .rise (ss_rise),
    .fall (ss_fall)
  );
  always_comb begin
    mosi_d     = {mosi_q[0], MOSI};
    lead       = mode_q.cpol ? sclk_fall : sclk_rise;
    trail      = mode_q.cpol ? sclk_rise : sclk_fall;
    smp        = mode_q.cpha ? trail : lead;
    // the shift edge that follows a wrap is skipped: the reload already put the new MSB out
    shf        = (mode_q.cpha ? lead : trail) && cnt_q != '0;
    wrap       = smp && cnt_q == CW'(WIDTH - 1);
    state_d    = state_q;
    mode_d     = mode_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    cnt_d      = cnt_q;
    rx_valid_d = 1'b0;
    tx_ready_d = 1'b0;
    abort_d    = 1'b0;
    if (state_q == IDLE) begin
      if (ss_fall) begin
        state_d    = SHIFT;
        mode_d     = clk_mode;
        tx_d       = tx_data;
        rx_sh_d    = '0;
        cnt_d      = '0;
        tx_ready_d = 1'b1;
      end
    end else if (ss_rise) begin
      state_d = IDLE;
      abort_d = cnt_q != '0;
      cnt_d   = '0;
    end else begin
      if (smp) begin
        rx_sh_d = {rx_sh_q[WIDTH-2:0], mosi_q[1]};
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
      end
      if (wrap) begin
        rx_data_d  = rx_sh_d;
        rx_valid_d = 1'b1;
        tx_d       = tx_data;
        tx_ready_d = 1'b1;
      end else if (shf) begin
        tx_d = {tx_q[WIDTH-2:0], 1'b0};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mosi_q     <= '0;
      state_q    <= IDLE;
      mode_q     <= '0;
      tx_q       <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      cnt_q      <= '0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      mosi_q     <= mosi_d;
      state_q    <= state_d;
      mode_q     <= mode_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      cnt_q      <= cnt_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      abort_q    <= abort_d;
    end
  end
  assign MISO_oe  = state_q == SHIFT;
  assign MISO     = MISO_oe & tx_q[WIDTH-1];
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = tx_ready_q;
  assign abort    = abort_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed self-checking bench for spi_slave acting as an SPI master
module tb_spi_slave;
  logic clk, reset, SCLK, SS_n, MOSI, MISO, MISO_oe, tx_ready, rx_valid, abort;
  logic [1:0] clk_mode;
  logic [7:0] tx_data, rx_data, got, got2;
  logic ok, ok2;
  int checks, errors, rxv_n, txr_n, abt_n, rv0, tr0, ab0;
  spi_slave #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .clk_mode(clk_mode),
    .SCLK    (SCLK),
    .SS_n    (SS_n),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .MISO_oe (MISO_oe),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .abort   (abort)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rx_valid) rxv_n <= rxv_n + 1;
    if (tx_ready) txr_n <= txr_n + 1;
    if (abort) abt_n <= abt_n + 1;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic snap();
    rv0 = rxv_n;
    tr0 = txr_n;
    ab0 = abt_n;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Drives nb bits of w with SCLK half-period 4 clk; returns MISO as the master samples it and
  // ok=0 if MISO moved on the edge where it must stay still.
  task automatic frame(input logic [1:0] m, input logic [7:0] w, input int nb,
                       output logic [7:0] g, output logic k_ok);
    logic cpol, cpha;
    cpol = m[1];
    cpha = m[0];
    g = '0;
    k_ok = 1'b1;
    for (int k = 0; k < nb; k++) begin
      if (!cpha) MOSI = w[7-k];
      wait_clk(4);
      if (cpha) begin
        if (k > 0 && MISO !== g[8-k]) k_ok = 1'b0;
        SCLK = ~cpol;
        MOSI = w[7-k];
        wait_clk(4);
        g[7-k] = MISO;
        SCLK = cpol;
      end else begin
        g[7-k] = MISO;
        SCLK = ~cpol;
        wait_clk(4);
        if (k < 7 && MISO !== g[7-k]) k_ok = 1'b0;
        SCLK = cpol;
      end
    end
    wait_clk(4);
  endtask
  initial begin
    reset = 1'b1;
    SS_n = 1'b1;
    SCLK = 1'b0;
    MOSI = 1'b0;
    clk_mode = 2'b00;
    tx_data = '0;
    wait_clk(3);
    check("rst_miso", MISO, 0);
    check("rst_oe", MISO_oe, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_abort", abort, 0);
    reset = 1'b0;
    wait_clk(2);
    snap();
    repeat (3) begin
      SCLK = 1'b1;
      wait_clk(4);
      SCLK = 1'b0;
      wait_clk(4);
    end
    check("idle_sclk_rxv", rxv_n - rv0, 0);
    check("idle_sclk_oe", MISO_oe, 0);
    for (int m = 0; m < 4; m++) begin
      logic [1:0] md;
      md = 2'(m);
      snap();
      tx_data = 8'hA5;
      clk_mode = md;
      SCLK = md[1];
      wait_clk(4);
      SS_n = 1'b0;
      wait_clk(4);
      clk_mode = ~md;
      check($sformatf("m%0d_oe", m), MISO_oe, 1);
      frame(md, 8'h3C, 8, got, ok);
      check($sformatf("m%0d_miso", m), got, 8'hA5);
      check($sformatf("m%0d_edge", m), ok, 1);
      check($sformatf("m%0d_rx_data", m), rx_data, 8'h3C);
      check($sformatf("m%0d_rxv", m), rxv_n - rv0, 1);
      SS_n = 1'b1;
      wait_clk(6);
      check($sformatf("m%0d_oe_off", m), MISO_oe, 0);
      check($sformatf("m%0d_miso_idle", m), MISO, 0);
      check($sformatf("m%0d_abort", m), abt_n - ab0, 0);
      check($sformatf("m%0d_txr", m), txr_n - tr0, 2);
    end
    clk_mode = 2'b00;
    SCLK = 1'b0;
    tx_data = 8'hF0;
    wait_clk(4);
    snap();
    SS_n = 1'b0;
    wait_clk(4);
    tx_data = 8'h0F;
    frame(2'b00, 8'h11, 8, got, ok);
    check("b2b_rx1", rx_data, 8'h11);
    frame(2'b00, 8'h22, 8, got2, ok2);
    check("b2b_rx2", rx_data, 8'h22);
    check("b2b_miso1", got, 8'hF0);
    check("b2b_miso2", got2, 8'h0F);
    check("b2b_edge", ok & ok2, 1);
    SS_n = 1'b1;
    wait_clk(6);
    check("b2b_rxv", rxv_n - rv0, 2);
    check("b2b_txr", txr_n - tr0, 3);
    check("b2b_abort", abt_n - ab0, 0);
    snap();
    tx_data = 8'h00;
    SS_n = 1'b0;
    wait_clk(4);
    frame(2'b00, 8'hFF, 5, got, ok);
    SS_n = 1'b1;
    wait_clk(6);
    check("abort_pulse", abt_n - ab0, 1);
    check("abort_rx_data", rx_data, 8'h22);
    check("abort_rxv", rxv_n - rv0, 0);
    check("abort_oe", MISO_oe, 0);
    snap();
    tx_data = 8'h5A;
    SS_n = 1'b0;
    wait_clk(4);
    frame(2'b00, 8'hFF, 3, got, ok);
    reset = 1'b1;
    wait_clk(2);
    check("rstmid_oe", MISO_oe, 0);
    SS_n = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(4);
    check("rstmid_rx_data", rx_data, 0);
    SS_n = 1'b0;
    wait_clk(4);
    frame(2'b00, 8'h81, 8, got, ok);
    SS_n = 1'b1;
    wait_clk(6);
    check("rstmid_frame", rx_data, 8'h81);
    check("rstmid_miso", got, 8'h5A);
    check("rstmid_abort", abt_n - ab0, 0);
    check("rstmid_rxv", rxv_n - rv0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: WIDTH, default 8, frame length in bits.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 clk_mode  input  2  {CPOL,CPHA}; sampled only in IDLE.
REQ-005 SCLK  input  1  serial clock from master; asynchronous to clk.
REQ-006 SS_n  input  1  active-low slave select; asynchronous.
REQ-007 MOSI  input  1  serial data from master; asynchronous.
REQ-008 MISO  output  1  serial data to master, MSB first.
REQ-009 MISO_oe  output  1  high while selected; MISO drives bus only when high.
REQ-010 tx_data  input  WIDTH  word to return on the next frame.
REQ-011 tx_ready  output  1  one-cycle pulse when tx_data has been captured.
REQ-012 rx_data  output  WIDTH  last complete received word.
REQ-013 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-014 abort  output  1  one-cycle pulse when SS_n rises mid-frame.

Function
REQ-015 SCLK, SS_n and MOSI SHALL pass through 2-flop synchronizers; edges are detected on the synchronized copies.
REQ-016 Leading edge = synchronized SCLK leaving CPOL; trailing edge = returning to CPOL.
REQ-017 FSM states IDLE, SHIFT; IDLE->SHIFT on synchronized SS_n falling; SHIFT->IDLE on synchronized SS_n rising.
REQ-018 On IDLE->SHIFT: latch clk_mode, load tx_data into shift register, clear bit count, pulse tx_ready.
REQ-019 CPHA=0: MSB on MISO in the cycle SHIFT is entered; sample MOSI on leading edge; shift MISO on trailing edge.
REQ-020 CPHA=1: shift MISO on leading edge (first leading edge presents MSB); sample MOSI on trailing edge.
REQ-021 Received bits SHALL enter MSB first; bit count is $clog2(WIDTH) bits wide and wraps to 0 after WIDTH-1.
REQ-022 On the sampling edge of bit WIDTH-1: rx_data <= assembled word and rx_valid pulses in the next clk cycle.
REQ-023 Back-to-back frames (SS_n held low): at wrap, reload tx_data, pulse tx_ready in the same cycle as rx_valid; next MSB driven per REQ-019/020.
REQ-024 SS_n rising with bit count != 0: discard partial word, rx_data unchanged, pulse abort, go IDLE.
REQ-025 SS_n rising with bit count == 0: go IDLE, no abort.
REQ-026 SCLK edges while IDLE SHALL be ignored; clk_mode changes in SHIFT SHALL be ignored.
REQ-027 MISO_oe = 1 exactly in SHIFT; MISO = 0 in IDLE.
REQ-028 Supported timing: SCLK high and low phases each >= 3 clk periods; SS_n setup to first SCLK edge >= 3 clk periods.

Reset
REQ-029 reset SHALL force: state IDLE, MISO 0, MISO_oe 0, rx_data 0, rx_valid 0, tx_ready 0, abort 0, bit count 0, shift registers 0, synchronizer flops to inactive (SS_n 1, SCLK 0, MOSI 0).
REQ-030 reset mid-frame SHALL discard the frame without abort pulse; after reset release the block waits for a fresh SS_n falling edge.

Structure
REQ-031 Package spi_pkg SHALL hold the clk_mode typedef and the state enum {IDLE, SHIFT}.
REQ-032 One sub-module spi_sync: 2-flop synchronizer plus rise/fall detect, instantiated for SCLK and SS_n (MOSI uses sync only).
REQ-033 Implementation targets 120-400 lines total.

Verification
REQ-034 Mode 0, tx_data=0xA5, master sends 0x3C, SCLK = 8 clk/period -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C; one rx_valid pulse.
REQ-035 Repeat REQ-034 in modes 1, 2, 3 -> identical data results; MISO changes only on the edge specified by CPHA.
REQ-036 SS_n held low for two frames, master 0x11 then 0x22, tx_data 0xF0 then 0x0F -> rx_valid twice (0x11, 0x22), MISO returns 0xF0 then 0x0F, tx_ready three pulses.
REQ-037 SS_n rises after 5 bits -> abort pulse, rx_data unchanged, no rx_valid, MISO_oe 0.
REQ-038 reset asserted after 3 bits, released, full frame 0x81 -> rx_data=0x81, no abort, no spurious rx_valid.
